comp_slice_accum: RTL

//  Downstream stage of the 2-bit comparator (comp2). Consumes one {A_gt_B,A_lt_B,A_eq_B}

---
 rtl/comp_pkg.sv | 17 +
 rtl/comp_slice_accum.sv | 89 ++++++++
 2 files changed

// File: rtl/comp_pkg.sv
// Shared encodings for the comparator slice chain: FSM state codes and the
// one-hot {gt,lt,eq} result encoding.
package comp_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [2:0] RES_GT = 3'b100;
  localparam logic [2:0] RES_LT = 3'b010;
  localparam logic [2:0] RES_EQ = 3'b001;

  function automatic logic flags_one_hot(input logic [2:0] f);
    return (f == RES_GT) || (f == RES_LT) || (f == RES_EQ);
  endfunction

endpackage

// File: rtl/comp_slice_accum.sv
// Folds NUM_SLICES comp2 flag triples (MSB slice first) into the magnitude
// result of a (2*NUM_SLICES)-bit compare, with start/valid-ready handshakes.
module comp_slice_accum
  import comp_pkg::*;
#(
  parameter  int NUM_SLICES = 4,
  localparam int CNT_W      = $clog2(NUM_SLICES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic in_valid,
  input  logic in_gt,
  input  logic in_lt,
  input  logic in_eq,
  output logic in_ready,
  output logic out_valid,
  input  logic out_ready,
  output logic A_gt_B,
  output logic A_lt_B,
  output logic A_eq_B,
  output logic err,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_SLICES - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       result;
  logic             decided;
  logic [2:0]       flags;

  assign flags = {in_gt, in_lt, in_eq};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      decided   <= 1'b0;
      result    <= '0;
      err       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_ACCUM;
            cnt     <= '0;
            decided <= 1'b0;
            err     <= 1'b0;
            result  <= RES_EQ;
          end
        end
        ST_ACCUM: begin
          if (in_valid) begin
            cnt <= cnt + CNT_W'(1);
            // Bad flags are flagged even after the word is decided; they never touch the result.
            if (!flags_one_hot(flags)) begin
              err <= 1'b1;
            end else if (!decided && flags != RES_EQ) begin
              result  <= flags;
              decided <= 1'b1;
            end
            if (cnt == CNT_LAST) begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign {A_gt_B, A_lt_B, A_eq_B} = result;
  assign in_ready = (state == ST_ACCUM);
  assign busy     = (state != ST_IDLE);

endmodule
